// File: rtl/ignition_arbiter_pkg.sv
// ignition_arbiter_pkg
//   Shared definitions for the igniter arbiter and the igniter it drives:
//   FSM state encoding, default datapath widths and cooldown counter width.
package ignition_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        SETTLE = 2'd2
    } arb_state_e;

    // Default widths shared with the igniter's delta and position ports.
    localparam int IGN_DELTA_W = 4;
    localparam int IGN_POS_W   = 3;

    // Cooldown counter width; holds COOLDOWN values up to 15.
    localparam int CD_W = 4;

endpackage

// File: rtl/ignition_arbiter_rr_pick.sv
// rr_priority_pick
//   Combinational round-robin picker. Searches req starting one above
//   last_grant and wrapping modulo N_REQ; reports the first requester found.
//   Ports:
//     req        in   N_REQ          request vector
//     last_grant in   clog2(N_REQ)   most recently granted index
//     grant      out  clog2(N_REQ)   chosen index (0 when valid is low)
//     valid      out  1              at least one request present
module rr_priority_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [$clog2(N_REQ)-1:0] grant,
    output logic                     valid
);
    localparam int IDX_W = $clog2(N_REQ);

    always_comb begin
        valid = 1'b0;
        grant = '0;
        // k runs 1..N_REQ so last_grant itself is visited last.
        for (int k = 1; k <= N_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/ignition_arbiter.sv
// ignition_arbiter
//   Shares one igniter between N_REQ requesters. Grants round-robin, issues
//   one jump (enable_jump + delta) per grant, then holds off for COOLDOWN
//   settle cycles. Counts position wrap-arounds caused by the jumps.
//   Ports:
//     sys_clk     in   1               clock, rising edge
//     clr_n       in   1               async active-low reset
//     req         in   N_REQ           level requests, held until ack
//     req_delta   in   N_REQ*DELTA_W   per-requester jump delta
//     position    in   POS_W           igniter position feedback
//     ack         out  N_REQ           one-hot grant pulse (FIRE cycle)
//     enable_jump out  1               jump strobe to igniter
//     delta       out  DELTA_W         jump delta to igniter
//     busy        out  1               high in FIRE and SETTLE
//     last_grant  out  clog2(N_REQ)    most recently granted requester
//     wrap_pulse  out  1               pulse after a boundary-crossing jump
//     lap_count   out  LAP_W           saturating boundary-crossing count
module ignition_arbiter
    import ignition_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DELTA_W  = IGN_DELTA_W,
    parameter int POS_W    = IGN_POS_W,
    parameter int COOLDOWN = 3,
    parameter int LAP_W    = 8
) (
    input  logic                       sys_clk,
    input  logic                       clr_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DELTA_W-1:0]   req_delta,
    input  logic [POS_W-1:0]           position,
    output logic [N_REQ-1:0]           ack,
    output logic                       enable_jump,
    output logic [DELTA_W-1:0]         delta,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   last_grant,
    output logic                       wrap_pulse,
    output logic [LAP_W-1:0]           lap_count
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int SUM_W = POS_W + DELTA_W;
    localparam int ADD_W = ((LAP_W > DELTA_W) ? LAP_W : DELTA_W) + 1;

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                enable_jump_q, enable_jump_d;
    logic [DELTA_W-1:0]  delta_q, delta_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic [LAP_W-1:0]    lap_count_q, lap_count_d;
    logic [CD_W-1:0]     cooldown_q, cooldown_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;
    logic [DELTA_W-1:0]  pick_delta;
    logic [SUM_W-1:0]    jump_sum;
    logic [DELTA_W-1:0]  crossings;

    function automatic logic [LAP_W-1:0] lap_sat_add(input logic [LAP_W-1:0] a,
                                                     input logic [DELTA_W-1:0] b);
        logic [ADD_W-1:0] s;
        s = ADD_W'(a) + ADD_W'(b);
        if (s > ADD_W'({LAP_W{1'b1}}))
            return {LAP_W{1'b1}};
        return LAP_W'(s);
    endfunction

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_idx),
        .valid      (pick_vld)
    );

    always_comb begin
        pick_delta = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i))
                pick_delta = req_delta[i*DELTA_W +: DELTA_W];
        end
    end

    // Position is the pre-jump value here: the igniter moves on the edge
    // that ends FIRE. Full-width sum so multiple laps in one jump count.
    assign jump_sum  = {{DELTA_W{1'b0}}, position} + {{POS_W{1'b0}}, delta_q};
    assign crossings = jump_sum[SUM_W-1:POS_W];

    always_comb begin
        state_d       = state_q;
        ack_d         = '0;
        enable_jump_d = 1'b0;
        delta_d       = '0;
        busy_d        = busy_q;
        last_grant_d  = last_grant_q;
        wrap_pulse_d  = 1'b0;
        lap_count_d   = lap_count_q;
        cooldown_d    = cooldown_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (pick_vld) begin
                    state_d         = FIRE;
                    ack_d[pick_idx] = 1'b1;
                    enable_jump_d   = 1'b1;
                    delta_d         = pick_delta;
                    busy_d          = 1'b1;
                    last_grant_d    = pick_idx;
                end
            end
            FIRE: begin
                wrap_pulse_d = |crossings;
                lap_count_d  = lap_sat_add(lap_count_q, crossings);
                cooldown_d   = CD_W'(COOLDOWN);
                busy_d       = 1'b1;
                state_d      = SETTLE;
            end
            SETTLE: begin
                busy_d     = 1'b1;
                cooldown_d = cooldown_q - CD_W'(1);
                if (cooldown_q <= CD_W'(1)) begin
                    cooldown_d = '0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= IDLE;
            ack_q         <= '0;
            enable_jump_q <= 1'b0;
            delta_q       <= '0;
            busy_q        <= 1'b0;
            last_grant_q  <= IDX_W'(N_REQ - 1);
            wrap_pulse_q  <= 1'b0;
            lap_count_q   <= '0;
            cooldown_q    <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            enable_jump_q <= enable_jump_d;
            delta_q       <= delta_d;
            busy_q        <= busy_d;
            last_grant_q  <= last_grant_d;
            wrap_pulse_q  <= wrap_pulse_d;
            lap_count_q   <= lap_count_d;
            cooldown_q    <= cooldown_d;
        end
    end

    assign ack         = ack_q;
    assign enable_jump = enable_jump_q;
    assign delta       = delta_q;
    assign busy        = busy_q;
    assign last_grant  = last_grant_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign lap_count   = lap_count_q;

endmodule

// File: tb/tb_ignition_arbiter.sv
// tb_ignition_arbiter
//   Directed test of ignition_arbiter with hand-computed expectations.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_ignition_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int PW = 3;
    localparam int LW = 8;

    logic          sys_clk = 1'b0;
    logic          clr_n   = 1'b0;
    logic [N-1:0]  req     = '0;
    logic [N*DW-1:0] req_delta = '0;
    logic [PW-1:0] position = '0;
    logic [N-1:0]  ack;
    logic          enable_jump;
    logic [DW-1:0] delta;
    logic          busy;
    logic [1:0]    last_grant;
    logic          wrap_pulse;
    logic [LW-1:0] lap_count;

    int n_total = 0;
    int n_bad   = 0;

    ignition_arbiter #(.N_REQ(N), .DELTA_W(DW), .POS_W(PW), .COOLDOWN(3), .LAP_W(LW)) dut (
        .sys_clk     (sys_clk),
        .clr_n       (clr_n),
        .req         (req),
        .req_delta   (req_delta),
        .position    (position),
        .ack         (ack),
        .enable_jump (enable_jump),
        .delta       (delta),
        .busy        (busy),
        .last_grant  (last_grant),
        .wrap_pulse  (wrap_pulse),
        .lap_count   (lap_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"},   32'(ack), 0);
        chk({tag, "_en"},    32'(enable_jump), 0);
        chk({tag, "_delta"}, 32'(delta), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_wrap"},  32'(wrap_pulse), 0);
        chk({tag, "_lap"},   32'(lap_count), 0);
        chk({tag, "_lastg"}, 32'(last_grant), 3);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        req   = '0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        clr_n = 1'b1;
    endtask

    // Waits (bounded) for an ack pulse; returns it, or 0 on timeout.
    task automatic wait_ack(input string tag, output logic [N-1:0] a);
        a = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (ack != '0) begin
                a = ack;
                break;
            end
        end
        if (a == '0) chk({tag, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!done) chk({tag, "_idle_timeout"}, 0, 1);
    endtask

    initial begin
        logic [N-1:0] a;
        int nbusy, ngr, prev;

        // ---- reset values ----
        @(negedge sys_clk);
        check_reset_vals("rst");
        clr_n = 1'b1;

        // ---- single jump, requester 0, delta 3 ----
        req_delta = {4'd0, 4'd0, 4'd0, 4'd3};
        position  = 3'd0;
        req       = 4'b0001;
        @(negedge sys_clk);
        chk("t1_ack",   32'(ack), 32'b0001);
        chk("t1_en",    32'(enable_jump), 1);
        chk("t1_delta", 32'(delta), 3);
        chk("t1_lastg", 32'(last_grant), 0);
        req   = '0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nbusy++;
            if (i == 1) chk("t1_settle_en", 32'(enable_jump), 0);
            if (i == 1) chk("t1_wrap", 32'(wrap_pulse), 0);
            @(negedge sys_clk);
        end
        chk("t1_busy_cycles", 32'(nbusy), 4);
        chk("t1_lap", 32'(lap_count), 0);

        // ---- all four requesting: order 0,1,2,3 spaced 5 ----
        do_reset();
        req_delta = {4'd4, 4'd3, 4'd2, 4'd1};
        req       = 4'b1111;
        ngr  = 0;
        prev = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge sys_clk);
            chk("t2_onehot", 32'($countones(ack) <= 1), 1);
            if (ack != '0) begin
                int idx;
                idx = 0;
                for (int b = 0; b < N; b++) if (ack[b]) idx = b;
                chk("t2_order", 32'(idx), 32'(ngr));
                chk("t2_delta", 32'(delta), 32'(idx + 1));
                if (ngr > 0) chk("t2_spacing", 32'(cyc - prev), 5);
                prev = cyc;
                ngr++;
                req = req & ~ack;
            end
        end
        chk("t2_count", 32'(ngr), 4);
        wait_idle("t2");

        // ---- position 6 + delta 5 -> one crossing ----
        position  = 3'd6;
        req_delta = {4'd0, 4'd0, 4'd0, 4'd5};
        req       = 4'b0001;
        wait_ack("t3", a);
        req = '0;
        chk("t3_ack", 32'(a), 32'b0001);
        chk("t3_wrap_fire", 32'(wrap_pulse), 0);
        @(negedge sys_clk);
        chk("t3_wrap", 32'(wrap_pulse), 1);
        chk("t3_lap", 32'(lap_count), 1);
        @(negedge sys_clk);
        chk("t3_wrap_off", 32'(wrap_pulse), 0);
        wait_idle("t3");

        // ---- position 7 + delta 15 = 22 -> two crossings ----
        position  = 3'd7;
        req_delta = {4'd0, 4'd0, 4'd0, 4'd15};
        req       = 4'b0001;
        wait_ack("t4", a);
        req = '0;
        chk("t4_delta", 32'(delta), 15);
        @(negedge sys_clk);
        chk("t4_wrap", 32'(wrap_pulse), 1);
        chk("t4_lap", 32'(lap_count), 3);
        wait_idle("t4");

        // ---- req0 persistent, req2 joins: grants 0, 2, 0 ----
        position  = 3'd0;
        req_delta = {4'd0, 4'd2, 4'd0, 4'd1};
        req       = 4'b0001;
        wait_ack("t5a", a);
        chk("t5_first", 32'(a), 32'b0001);
        req = 4'b0101;
        wait_ack("t5b", a);
        chk("t5_second", 32'(a), 32'b0100);
        chk("t5_second_delta", 32'(delta), 2);
        req = 4'b0001;
        wait_ack("t5c", a);
        chk("t5_third", 32'(a), 32'b0001);
        req = '0;
        wait_idle("t5");

        // ---- reset in the middle of SETTLE ----
        req = 4'b0010;
        wait_ack("t6", a);
        chk("t6_grant", 32'(a), 32'b0010);
        req = '0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("t6_mid_busy", 32'(busy), 1);
        clr_n = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        @(negedge sys_clk);
        clr_n = 1'b1;
        req   = 4'b0100;
        wait_ack("t6b", a);
        chk("t6_after_grant", 32'(a), 32'b0100);
        chk("t6_after_lastg", 32'(last_grant), 2);
        req = '0;
        wait_idle("t6b");

        // ---- delta 0: jump fires, no wrap ----
        position  = 3'd5;
        req_delta = {4'd0, 4'd0, 4'd0, 4'd0};
        req       = 4'b0001;
        wait_ack("t7", a);
        req = '0;
        chk("t7_en", 32'(enable_jump), 1);
        chk("t7_delta", 32'(delta), 0);
        @(negedge sys_clk);
        chk("t7_wrap", 32'(wrap_pulse), 0);
        chk("t7_lap", 32'(lap_count), 0);
        wait_idle("t7");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ignition_arbiter.md
Name: ignition_arbiter

Overview:
- Shares one igniter position datapath between N_REQ requesters (players/launch sources).
- Arbitrates round-robin, drives the igniter's enable_jump/delta inputs one jump at a time, and enforces a settle (cooldown) window between jumps.
- Tracks position wrap-around (laps) from the igniter's position feedback.
- Sits between the requester logic and the igniter, which is instantiated beside it in the top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DELTA_W, 4, width of each jump delta; matches the igniter delta port.
- POS_W, 3, width of the igniter position; position wraps modulo 2**POS_W.
- COOLDOWN, 3, settle cycles after each jump before the next grant (1..15).
- LAP_W, 8, lap counter width.

Ports:
- sys_clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester jump request, level; held until its ack.
- req_delta  in  N_REQ*DELTA_W  per-requester delta; slice i = bits [i*DELTA_W +: DELTA_W]; must be stable while req[i]=1.
- position  in  POS_W  current igniter position (feedback).
- ack  out  N_REQ  one-hot, one-cycle grant/complete pulse.
- enable_jump  out  1  to igniter; one-cycle pulse per jump.
- delta  out  DELTA_W  to igniter; the latched delta of the granted requester.
- busy  out  1  high in FIRE and SETTLE.
- last_grant  out  clog2(N_REQ)  index of the most recently granted requester.
- wrap_pulse  out  1  one-cycle pulse when a jump crosses the position boundary.
- lap_count  out  LAP_W  total boundary crossings since reset.

Behaviour:
- Reset values (async on clr_n low):
  - state=IDLE.
  - ack=0, enable_jump=0, delta=0, busy=0, wrap_pulse=0, lap_count=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - Cooldown counter = 0.
- All outputs are registered.
- IDLE:
  - If any req is high, grant the first requester found searching from last_grant+1 upward, modulo N_REQ.
  - Latch that requester's delta slice; update last_grant; go to FIRE.
  - With no req: stay in IDLE, outputs at idle values.
- FIRE (exactly 1 cycle):
  - enable_jump=1, delta=latched value, ack[grant]=1, busy=1.
  - Compute sum = position + delta at full width (POS_W+DELTA_W bits).
  - Crossings = sum >> POS_W (0..2 for the defaults).
  - If crossings is nonzero: wrap_pulse=1 in the next cycle, and lap_count += crossings (saturates at all-ones).
  - Load cooldown = COOLDOWN; go to SETTLE.
- SETTLE:
  - busy=1, enable_jump=0, ack=0.
  - Decrement the cooldown each cycle; on reaching 0, go to IDLE.
  - Requests are ignored until IDLE.
- Latency and throughput:
  - req seen in IDLE → enable_jump/ack asserted on the next cycle.
  - Back-to-back jumps are spaced 2+COOLDOWN cycles apart.
- Handshake:
  - A requester drops req within one cycle of ack.
  - If req is still high on return to IDLE, it is treated as a new request; round-robin still puts the others first.
  - A req deasserted before it is granted is simply not served; no error.
- delta=0 is legal: the jump fires, position is unchanged, no wrap.
- Simultaneous requests: exactly one grant per jump, never two bits of ack high.
- Reset mid-FIRE or mid-SETTLE: immediate return to reset values; no partial pulse survives.
- position is assumed to change only because of this block's enable_jump.
- Wrap is computed from the position sampled in FIRE, i.e. the pre-jump value, since the igniter updates on the same edge.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, FIRE=2'd1, SETTLE=2'd2.
  - Default DELTA_W/POS_W constants shared with the igniter.
- One natural sub-module: rr_priority_pick.
  - Combinational round-robin picker.
  - Inputs: req, last_grant. Outputs: grant index, valid.
  - Reusable by other arbiters.

Test Plan:
- Reset, then req=4'b0001, delta0=3, position=0:
  - ack=0001 and enable_jump=1 with delta=3 one cycle after req.
  - busy high for 1+3 cycles.
  - no wrap; lap_count=0.
- req=4'b1111 held, ack dropping each req one cycle later:
  - grants in order 0,1,2,3, each spaced 5 cycles apart.
  - ack always one-hot.
- position=6, granted delta=5 → wrap_pulse once; lap_count=1.
- position=7, delta=15 (sum=22) → crossings=2; lap_count +=2.
- Requester 0 re-requests continuously while requester 2 also requests after grant 0 → next grant is 2, then 0.
- clr_n low during SETTLE (mid-cooldown):
  - all outputs at reset values immediately.
  - after release, req=0100 → grant 2 (search from last_grant=3 wraps to 0 first; 0 not requesting, so 2).
- Check: delta=0 jump → enable_jump pulses, no wrap_pulse.
